// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline definitions: bus widths, default frame geometry and
// the frame-reader FSM encoding, reused by the frame buffer controller and DWT.
package jpeg_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WORD_W = 32;

    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    // Byte 0 is [31:24], the earliest camera byte in the word.
    function automatic logic [PIX_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        idx);
        logic [PIX_W-1:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sram_word_fifo.sv
// Synchronous first-word-fall-through FIFO for SRAM read words, with an
// occupancy count used by the reader's read-credit logic.
module sram_word_fifo
    import jpeg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_100,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WORD_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [WORD_W-1:0]          rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              do_wr;
    logic              do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_100) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/dwt_sram_reader.sv
// Frame fetch stage: walks the stored frame in SRAM, buffers returned words
// and streams unpacked pixels in raster order to the DWT over valid/ready.
module dwt_sram_reader
    import jpeg_pkg::*;
#(
    parameter int unsigned       IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int unsigned       IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int unsigned       READ_LATENCY = 2,
    parameter int unsigned       FIFO_DEPTH   = 4
) (
    input  logic              clk_100,
    input  logic              rst,
    input  logic              jpeg_start,
    input  logic [WORD_W-1:0] data_to_jpeg,
    output logic [ADDR_W-1:0] address_from_dwt,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic              row_last,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned TOTAL_WORDS = IMG_WIDTH * IMG_HEIGHT / 4;
    localparam int unsigned ISSUE_W     = ADDR_W + 1;
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W       = CNT_W + 2;
    localparam int unsigned IFL_W       = $clog2(READ_LATENCY + 1);

    rd_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ISSUE_W-1:0]      issued_q;
    logic [READ_LATENCY-1:0] inflight_q;
    logic [IFL_W-1:0]        inflight_cnt_q;
    logic                    inflight_tail;

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [WORD_W-1:0]       fifo_rdata;
    logic                    fifo_pop;

    logic [WORD_W-1:0]       word_q;
    logic [1:0]              byte_idx_q;
    logic                    pix_valid_q;
    logic [9:0]              x_q, y_q;

    logic                    start;
    logic                    issue;
    logic                    accept;
    logic                    last_pixel;
    logic [OCC_W-1:0]        occupancy;

    // The word held by the unpacker still occupies a buffer slot, so at most
    // FIFO_DEPTH words are ever outstanding between SRAM and the DWT.
    assign occupancy     = OCC_W'(inflight_cnt_q) + OCC_W'(fifo_count) + OCC_W'(pix_valid_q);
    assign start         = (state_q == ST_IDLE) && jpeg_start;
    assign issue         = start ||
                           ((state_q == ST_RUN) && (issued_q < ISSUE_W'(TOTAL_WORDS)) &&
                            (occupancy < OCC_W'(FIFO_DEPTH)));
    assign inflight_tail = inflight_q[READ_LATENCY-1];
    assign accept        = pix_valid_q && pixel_ready;
    assign last_pixel    = accept && (x_q == 10'(IMG_WIDTH - 1)) && (y_q == 10'(IMG_HEIGHT - 1));
    assign fifo_pop      = !fifo_empty && (!pix_valid_q || (accept && (byte_idx_q == 2'd3)));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = BASE_ADDR;
                if (jpeg_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (issue) addr_d = addr_q + ADDR_W'(1);
                if (issued_q == ISSUE_W'(TOTAL_WORDS)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_pixel) state_d = ST_DONE;
            end
            ST_DONE: begin
                addr_d  = BASE_ADDR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= BASE_ADDR;
            issued_q       <= '0;
            inflight_q     <= '0;
            inflight_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            inflight_q     <= (inflight_q << 1) | READ_LATENCY'(issue);
            inflight_cnt_q <= inflight_cnt_q + IFL_W'(issue) - IFL_W'(inflight_tail);
            if (issue) issued_q <= start ? ISSUE_W'(1) : issued_q + ISSUE_W'(1);
        end
    end

    sram_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100 (clk_100),
        .rst     (rst),
        .wr_en   (inflight_tail),
        .wr_data (data_to_jpeg),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            word_q      <= '0;
            byte_idx_q  <= '0;
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            if (fifo_pop) begin
                word_q      <= fifo_rdata;
                byte_idx_q  <= '0;
                pix_valid_q <= 1'b1;
            end else if (accept) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) pix_valid_q <= 1'b0;
            end

            if (start) begin
                x_q <= '0;
                y_q <= '0;
            end else if (accept) begin
                if (x_q == 10'(IMG_WIDTH - 1)) begin
                    x_q <= '0;
                    y_q <= (y_q == 10'(IMG_HEIGHT - 1)) ? '0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

    assign address_from_dwt = addr_q;
    assign pixel_data       = word_byte(word_q, byte_idx_q);
    assign pixel_valid      = pix_valid_q;
    assign pixel_x          = x_q;
    assign pixel_y          = y_q;
    assign row_last         = pix_valid_q && (x_q == 10'(IMG_WIDTH - 1));
    assign frame_done       = (state_q == ST_DONE);
    assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_dwt_sram_reader.sv
// Scoreboard bench for dwt_sram_reader on a small 8x4 frame, with an SRAM
// model that returns word = address after a fixed read latency.
module tb_dwt_sram_reader;

    localparam int unsigned W     = 8;
    localparam int unsigned H     = 4;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 4;
    localparam logic [17:0] BASE  = 18'h00123;
    localparam int unsigned WORDS = W * H / 4;
    localparam int          DONE_AT = RL + 1 + W * H;

    typedef logic [28:0] pix_t;  // {data, x, y, row_last}

    logic        clk_100 = 1'b0;
    logic        rst = 1'b0;
    logic        jpeg_start = 1'b0;
    logic [31:0] data_to_jpeg;
    logic [17:0] address_from_dwt;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;
    logic [9:0]  pixel_x, pixel_y;
    logic        row_last, frame_done, busy;

    int   checks = 0;
    int   failures = 0;
    pix_t sb[$];

    dwt_sram_reader #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_100          (clk_100),
        .rst              (rst),
        .jpeg_start       (jpeg_start),
        .data_to_jpeg     (data_to_jpeg),
        .address_from_dwt (address_from_dwt),
        .pixel_data       (pixel_data),
        .pixel_valid      (pixel_valid),
        .pixel_ready      (pixel_ready),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .row_last         (row_last),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    always #5 clk_100 = ~clk_100;

    // One register stage plus the DUT's registered address gives RL=2 edges.
    logic [17:0] sram_addr_q = '0;
    always @(posedge clk_100) sram_addr_q <= address_from_dwt;
    assign data_to_jpeg = {14'd0, sram_addr_q};

    task automatic push_frame();
        logic [31:0] w;
        int unsigned p;
        for (int unsigned i = 0; i < WORDS; i++) begin
            w = {14'd0, 18'(BASE + i)};
            for (int unsigned b = 0; b < 4; b++) begin
                p = 4 * i + b;
                sb.push_back({w[31 - 8*b -: 8], 10'(p % W), 10'(p / W), (p % W) == W - 1});
            end
        end
    endtask

    // Leaves the caller on the negedge right after the start edge E0.
    task automatic start_frame();
        @(negedge clk_100);
        jpeg_start = 1'b1;
        push_frame();
        @(negedge clk_100);
        jpeg_start = 1'b0;
    endtask

    task automatic consume_frame(input int unsigned duty, input int restart_at,
                                 output int first_valid, output int done_cycle);
        pix_t held, act, exp;
        logic stalled, last_seen;
        int   max_fifo;
        first_valid = -1;
        done_cycle  = -1;
        stalled     = 1'b0;
        last_seen   = 1'b0;
        max_fifo    = 0;
        for (int c = 0; c < 2000; c++) begin
            act = {pixel_data, pixel_x, pixel_y, row_last};
            if (int'(dut.fifo_count) > max_fifo) max_fifo = int'(dut.fifo_count);
            if (frame_done) begin
                done_cycle = c;
                checks++;
                if (!last_seen || sb.size() != 0) begin
                    failures++;
                    $display("FAIL frame_done_early: cycle %0d with %0d pixels outstanding, required after last transfer", c, sb.size());
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done: got %b, required 0", busy);
                end
                break;
            end
            if (last_seen) begin
                checks++;
                failures++;
                done_cycle = c;
                $display("FAIL frame_done_missing: got 0 the cycle after the last transfer, required 1");
                break;
            end
            if (stalled) begin
                checks++;
                if ({pixel_valid, act} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b %h, required valid=1 %h", pixel_valid, act, held);
                end
            end
            jpeg_start  = (c == restart_at);
            pixel_ready = ($urandom_range(99) < duty);
            if (pixel_valid && first_valid < 0) first_valid = c;
            stalled = pixel_valid && !pixel_ready;
            held    = act;
            if (pixel_valid && pixel_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_pixel: got %h, required no transfer", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL pixel: got %h, required %h ({data,x,y,row_last})", act, exp);
                    end
                    if (sb.size() == 0) last_seen = 1'b1;
                end
            end
            @(negedge clk_100);
        end
        jpeg_start  = 1'b0;
        pixel_ready = 1'b0;
        if (done_cycle < 0) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got no frame_done in 2000 cycles, required one");
        end
        checks++;
        if (max_fifo > int'(DEPTH)) begin
            failures++;
            $display("FAIL fifo_count_bound: got %0d, required <= %0d", max_fifo, DEPTH);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_100);
        checks++;
        if ({address_from_dwt, pixel_data, pixel_valid, pixel_x, pixel_y, row_last, frame_done, busy}
            !== {BASE, 8'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h data=%h v=%b x=%0d y=%0d rl=%b fd=%b busy=%b, required addr=%h all others 0",
                     address_from_dwt, pixel_data, pixel_valid, pixel_x, pixel_y, row_last, frame_done, busy, BASE);
        end
        rst = 1'b1;
    endtask

    task automatic test_full_frame();
        int fv, dc;
        start_frame();
        checks++;
        if ({busy, frame_done, address_from_dwt} !== {1'b1, 1'b0, BASE}) begin
            failures++;
            $display("FAIL start_state: got busy=%b fd=%b addr=%h, required busy=1 fd=0 addr=%h",
                     busy, frame_done, address_from_dwt, BASE);
        end
        consume_frame(100, -1, fv, dc);
        checks++;
        if (fv != int'(RL + 1)) begin
            failures++;
            $display("FAIL first_pixel_latency: got %0d, required %0d", fv, RL + 1);
        end
        checks++;
        if (dc != DONE_AT) begin
            failures++;
            $display("FAIL frame_done_cycle: got %0d, required %0d", dc, DONE_AT);
        end
        @(negedge clk_100);
        checks++;
        if ({frame_done, busy, pixel_y} !== {1'b0, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL after_done: got fd=%b busy=%b y=%0d, required 0 0 0", frame_done, busy, pixel_y);
        end
    endtask

    task automatic test_random_ready();
        int fv, dc;
        start_frame();
        consume_frame(30, -1, fv, dc);
    endtask

    task automatic test_stall_start();
        int fv, dc;
        logic [17:0] max_addr;
        start_frame();
        pixel_ready = 1'b0;
        max_addr = address_from_dwt;
        repeat (100) begin
            @(negedge clk_100);
            if (address_from_dwt > max_addr) max_addr = address_from_dwt;
        end
        checks++;
        if (max_addr !== BASE + 18'(DEPTH - 1)) begin
            failures++;
            $display("FAIL stall_addr_limit: got %h, required %h", max_addr, BASE + 18'(DEPTH - 1));
        end
        checks++;
        if ({pixel_valid, pixel_data} !== {1'b1, sb[0][28:21]}) begin
            failures++;
            $display("FAIL stall_first_pixel: got v=%b data=%h, required v=1 data=%h", pixel_valid, pixel_data, sb[0][28:21]);
        end
        consume_frame(100, -1, fv, dc);
    endtask

    task automatic test_back_to_back();
        int fv, dc;
        start_frame();
        consume_frame(70, 10, fv, dc);
        start_frame();
        checks++;
        if ({busy, frame_done, address_from_dwt} !== {1'b1, 1'b0, BASE}) begin
            failures++;
            $display("FAIL restart_state: got busy=%b fd=%b addr=%h, required busy=1 fd=0 addr=%h",
                     busy, frame_done, address_from_dwt, BASE);
        end
        consume_frame(100, -1, fv, dc);
        checks++;
        if (dc != DONE_AT) begin
            failures++;
            $display("FAIL restart_done_cycle: got %0d, required %0d", dc, DONE_AT);
        end
    endtask

    task automatic test_async_reset();
        int quiet_fail;
        start_frame();
        pixel_ready = 1'b0;
        repeat (15) @(negedge clk_100);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({address_from_dwt, pixel_data, pixel_valid, pixel_x, pixel_y, row_last, frame_done, busy}
            !== {BASE, 8'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_outputs: got addr=%h data=%h v=%b x=%0d y=%0d rl=%b fd=%b busy=%b, required addr=%h all others 0",
                     address_from_dwt, pixel_data, pixel_valid, pixel_x, pixel_y, row_last, frame_done, busy, BASE);
        end
        sb.delete();
        @(negedge clk_100);
        rst = 1'b1;
        quiet_fail = 0;
        repeat (10) begin
            @(negedge clk_100);
            if (frame_done || busy || pixel_valid) quiet_fail++;
        end
        checks++;
        if (quiet_fail != 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d active cycles after reset, required 0", quiet_fail);
        end
        test_full_frame();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_ready();
        test_stall_start();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
